// File: rtl/out_port_uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : nic8_uart_pkg
//  Description : Shared TX state encoding and UART constants for the CPU
//                output-port serializer.
//  Revision    : 1.0 - initial release
// ============================================================================
package nic8_uart_pkg;

    localparam int   UART_DATA_BITS  = 8;
    localparam logic UART_IDLE_LEVEL = 1'b1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_t;

    function automatic logic even_parity(input logic [UART_DATA_BITS-1:0] d);
        return ^d;
    endfunction

endpackage
`default_nettype wire

// File: rtl/out_port_uart_if.sv
`default_nettype none
// ============================================================================
//  Module      : out_port_uart_if
//  Description : Output-port strobe/data bus plus serial line and status.
//  Revision    : 1.0 - initial release
// ============================================================================
interface out_port_uart_if;
    import nic8_uart_pkg::*;

    logic                      doOut;
    logic [UART_DATA_BITS-1:0] dbus;
    logic                      txd;
    logic                      busy;
    logic                      full;
    logic                      dropped;

    modport master (
        output doOut,
        output dbus,
        input  txd,
        input  busy,
        input  full,
        input  dropped
    );

    modport slave (
        input  doOut,
        input  dbus,
        output txd,
        output busy,
        output full,
        output dropped
    );

endinterface
`default_nettype wire

// File: rtl/out_port_uart_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : out_fifo
//  Description : DEPTH x 8 byte FIFO with show-ahead read; a pop on the same
//                edge frees a slot for a push even when full.
//  Revision    : 1.0 - initial release
// ============================================================================
module out_fifo
    import nic8_uart_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  wire                              clk,
    input  wire                              resetB,
    input  wire                              push,
    input  wire                              pop,
    input  wire  [UART_DATA_BITS-1:0]        din,
    output logic [UART_DATA_BITS-1:0]        dout,
    output logic [$clog2(DEPTH+1)-1:0]       count,
    output logic                             full,
    output logic                             empty
);

    localparam int c_PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int c_CNT_W = $clog2(DEPTH + 1);

    logic [UART_DATA_BITS-1:0] r_mem [DEPTH];
    logic [c_PTR_W-1:0]        r_wr_ptr;
    logic [c_PTR_W-1:0]        r_rd_ptr;
    logic [c_CNT_W-1:0]        r_count;
    logic                      r_full;
    logic [c_CNT_W-1:0]        w_count_next;
    logic                      w_do_push;
    logic                      w_do_pop;

    assign w_do_pop  = pop && (r_count != '0);
    assign w_do_push = push && (!r_full || w_do_pop);

    always_comb begin
        w_count_next = r_count;
        case ({w_do_push, w_do_pop})
            2'b10:   w_count_next = r_count + c_CNT_W'(1);
            2'b01:   w_count_next = r_count - c_CNT_W'(1);
            default: w_count_next = r_count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge resetB) begin
        if (!resetB) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_full   <= 1'b0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            end
            r_count <= w_count_next;
            r_full  <= (w_count_next == c_CNT_W'(DEPTH));
        end
    end

    assign dout  = r_mem[r_rd_ptr];
    assign count = r_count;
    assign full  = r_full;
    assign empty = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/out_port_uart.sv
`default_nettype none
// ============================================================================
//  Module      : out_port_uart
//  Description : Captures output-port strobes into a FIFO and serializes them
//                as 8N1 (8E1 with OUT_PORT_UART_PARITY_EN defined), LSB first.
//  Revision    : 1.0 - initial release
// ============================================================================
module out_port_uart
    import nic8_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter int DEPTH        = 4
) (
    input wire             clk,
    input wire             resetB,
    out_port_uart_if.slave bus
);

    localparam int c_CNT_W  = $clog2(DEPTH + 1);
    localparam int c_BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int c_BIT_W  = $clog2(UART_DATA_BITS);
    localparam logic [c_BAUD_W-1:0] c_BAUD_LAST = c_BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [c_BIT_W-1:0]  c_BIT_LAST  = c_BIT_W'(UART_DATA_BITS - 1);

    tx_state_t                 r_state;
    tx_state_t                 w_state_next;
    logic [c_BAUD_W-1:0]       r_baud;
    logic [c_BAUD_W-1:0]       w_baud_next;
    logic [c_BIT_W-1:0]        r_bit;
    logic [c_BIT_W-1:0]        w_bit_next;
    logic [UART_DATA_BITS-1:0] r_shift;
    logic [UART_DATA_BITS-1:0] w_shift_next;
    logic                      r_parity;
    logic                      w_parity_next;
    logic                      r_txd;
    logic                      w_txd_next;
    logic                      r_busy;
    logic                      w_busy_next;
    logic                      r_dropped;
    logic                      w_pop;
    logic                      w_baud_done;

    logic [UART_DATA_BITS-1:0] w_fifo_dout;
    logic [c_CNT_W-1:0]        w_fifo_count;
    logic                      w_fifo_full;
    logic                      w_unused_empty;

    out_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk    (clk),
        .resetB (resetB),
        .push   (bus.doOut),
        .pop    (w_pop),
        .din    (bus.dbus),
        .dout   (w_fifo_dout),
        .count  (w_fifo_count),
        .full   (w_fifo_full),
        .empty  (w_unused_empty)
    );

    assign w_baud_done = (r_baud == c_BAUD_LAST);

    always_ff @(posedge clk or negedge resetB) begin
        if (!resetB) begin
            r_state  <= IDLE;
            r_baud   <= '0;
            r_bit    <= '0;
            r_shift  <= '0;
            r_parity <= 1'b0;
            r_txd    <= UART_IDLE_LEVEL;
            r_busy   <= 1'b0;
        end else begin
            r_state  <= w_state_next;
            r_baud   <= w_baud_next;
            r_bit    <= w_bit_next;
            r_shift  <= w_shift_next;
            r_parity <= w_parity_next;
            r_txd    <= w_txd_next;
            r_busy   <= w_busy_next;
        end
    end

    // txd is computed one cycle ahead so the line itself is a flop output.
    always_comb begin
        w_state_next  = r_state;
        w_baud_next   = r_baud;
        w_bit_next    = r_bit;
        w_shift_next  = r_shift;
        w_parity_next = r_parity;
        w_txd_next    = r_txd;
        w_busy_next   = r_busy;
        w_pop         = 1'b0;
        case (r_state)
            IDLE: begin
                w_txd_next = UART_IDLE_LEVEL;
                if (w_fifo_count != '0) begin
                    w_pop         = 1'b1;
                    w_shift_next  = w_fifo_dout;
                    w_parity_next = even_parity(w_fifo_dout);
                    w_busy_next   = 1'b1;
                    w_txd_next    = ~UART_IDLE_LEVEL;
                    w_baud_next   = '0;
                    w_bit_next    = '0;
                    w_state_next  = START;
                end
            end
            START: begin
                if (w_baud_done) begin
                    w_baud_next  = '0;
                    w_txd_next   = r_shift[0];
                    w_state_next = DATA;
                end else begin
                    w_baud_next = r_baud + c_BAUD_W'(1);
                end
            end
            DATA: begin
                if (w_baud_done) begin
                    w_baud_next = '0;
                    if (r_bit == c_BIT_LAST) begin
`ifdef OUT_PORT_UART_PARITY_EN
                        w_txd_next   = r_parity;
                        w_state_next = PARITY;
`else
                        w_txd_next   = UART_IDLE_LEVEL;
                        w_state_next = STOP;
`endif
                    end else begin
                        w_bit_next   = r_bit + c_BIT_W'(1);
                        w_shift_next = r_shift >> 1;
                        w_txd_next   = r_shift[1];
                    end
                end else begin
                    w_baud_next = r_baud + c_BAUD_W'(1);
                end
            end
            PARITY: begin
`ifdef OUT_PORT_UART_PARITY_EN
                if (w_baud_done) begin
                    w_baud_next  = '0;
                    w_txd_next   = UART_IDLE_LEVEL;
                    w_state_next = STOP;
                end else begin
                    w_baud_next = r_baud + c_BAUD_W'(1);
                end
`else
                w_baud_next  = '0;
                w_txd_next   = UART_IDLE_LEVEL;
                w_busy_next  = 1'b0;
                w_state_next = IDLE;
`endif
            end
            STOP: begin
                if (w_baud_done) begin
                    w_baud_next  = '0;
                    w_txd_next   = UART_IDLE_LEVEL;
                    w_busy_next  = 1'b0;
                    w_state_next = IDLE;
                end else begin
                    w_baud_next = r_baud + c_BAUD_W'(1);
                end
            end
            default: begin
                w_baud_next  = '0;
                w_txd_next   = UART_IDLE_LEVEL;
                w_busy_next  = 1'b0;
                w_state_next = IDLE;
            end
        endcase
    end

    // A write racing the IDLE pop is accepted by the FIFO, so it is not a drop.
    always_ff @(posedge clk or negedge resetB) begin
        if (!resetB) begin
            r_dropped <= 1'b0;
        end else if (bus.doOut && w_fifo_full && !w_pop) begin
            r_dropped <= 1'b1;
        end
    end

    assign bus.txd     = r_txd;
    assign bus.busy    = r_busy;
    assign bus.full    = w_fifo_full;
    assign bus.dropped = r_dropped;

endmodule
`default_nettype wire

// File: tb/tb_out_port_uart.sv
`default_nettype none
// ============================================================================
//  Module      : tb_out_port_uart
//  Description : Scoreboard bench for out_port_uart (CLKS_PER_BIT=4, DEPTH=4).
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_out_port_uart;

    localparam int CLKS_PER_BIT = 4;
    localparam int DEPTH        = 4;
`ifdef OUT_PORT_UART_PARITY_EN
    localparam int FRAME_BITS   = 11;
`else
    localparam int FRAME_BITS   = 10;
`endif
    localparam int FRAME_CYC    = FRAME_BITS * CLKS_PER_BIT;

    logic clk    = 1'b0;
    logic resetB = 1'b1;
    int   checks = 0;
    int   errors = 0;
    logic [7:0] exp_q [$];

    out_port_uart_if bus ();

    out_port_uart #(
        .CLKS_PER_BIT (CLKS_PER_BIT),
        .DEPTH        (DEPTH)
    ) dut (
        .clk    (clk),
        .resetB (resetB),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

    // Waits (bounded) for a start bit, then samples every bit mid-window.
    task automatic rx_frame(output logic [7:0] data, output logic par, output logic stop,
                            output int busy_cnt, output int waited, output logic gap_idle);
        int w;
        int b;
        data = 'x; par = 'x; stop = 'x; busy_cnt = 0; gap_idle = 1'b0;
        w = 0;
        while (bus.txd !== 1'b0 && w < 400) begin
            @(negedge clk);
            w++;
        end
        waited = w;
        if (bus.txd !== 1'b0) return;
        for (int k = 0; k < FRAME_CYC; k++) begin
            if (k > 0) @(negedge clk);
            if (bus.busy === 1'b1) busy_cnt++;
            if ((k % CLKS_PER_BIT) == CLKS_PER_BIT / 2) begin
                b = k / CLKS_PER_BIT;
                if (b == 0 && bus.txd !== 1'b0) data = 'x;
                if (b >= 1 && b <= 8) data[b-1] = bus.txd;
                if (b == 9 && FRAME_BITS == 11) par = bus.txd;
                if (b == FRAME_BITS - 1) stop = bus.txd;
            end
        end
        @(negedge clk);
        gap_idle = (bus.txd === 1'b1) && (bus.busy === 1'b0);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        resetB = 1'b0;
        repeat (2) @(negedge clk);
        resetB = 1'b1;
        @(negedge clk);
        exp_q.delete();
    endtask

    task automatic test_reset();
        bus.doOut = 1'b0;
        bus.dbus  = 8'h00;
        #1 resetB = 1'b0;
        #1;
        checks++; if (bus.txd !== 1'b1) begin errors++; $display("FAIL reset_txd: got %b required 1", bus.txd); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b required 0", bus.busy); end
        checks++; if (bus.full !== 1'b0) begin errors++; $display("FAIL reset_full: got %b required 0", bus.full); end
        checks++; if (bus.dropped !== 1'b0) begin errors++; $display("FAIL reset_dropped: got %b required 0", bus.dropped); end
        repeat (3) @(negedge clk);
        resetB = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (bus.txd !== 1'b1 || bus.busy !== 1'b0) begin
            errors++; $display("FAIL post_reset_idle: txd=%b busy=%b required txd=1 busy=0", bus.txd, bus.busy);
        end
    endtask

    task automatic test_single_byte();
        logic [7:0] d, e;
        logic p, s, g;
        int bc, w;
        fork
            begin
                bus.doOut = 1'b1; bus.dbus = 8'hA5; exp_q.push_back(8'hA5);
                @(negedge clk);
                bus.doOut = 1'b0;
            end
            rx_frame(d, p, s, bc, w, g);
        join
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
        checks++; if (w !== 2) begin errors++; $display("FAIL single_latency: got %0d cycles required 2", w); end
        checks++; if (d !== e) begin errors++; $display("FAIL single_data: got %h required %h", d, e); end
        checks++; if (s !== 1'b1) begin errors++; $display("FAIL single_stop: got %b required 1", s); end
        checks++; if (bc !== FRAME_CYC) begin errors++; $display("FAIL single_busy_len: got %0d required %0d", bc, FRAME_CYC); end
        checks++; if (g !== 1'b1) begin errors++; $display("FAIL single_idle_after: got %b required 1", g); end
    endtask

    task automatic test_back_to_back();
        fork
            begin
                for (int i = 1; i <= 3; i++) begin
                    bus.doOut = 1'b1; bus.dbus = 8'(i); exp_q.push_back(8'(i));
                    @(negedge clk);
                end
                bus.doOut = 1'b0;
            end
            begin
                logic [7:0] d, e;
                logic p, s, g;
                int bc, w;
                for (int f = 0; f < 3; f++) begin
                    rx_frame(d, p, s, bc, w, g);
                    e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
                    checks++; if (d !== e) begin errors++; $display("FAIL b2b_data[%0d]: got %h required %h", f, d, e); end
                    checks++; if (w !== ((f == 0) ? 2 : 1)) begin
                        errors++; $display("FAIL b2b_gap[%0d]: got %0d required %0d", f, w, (f == 0) ? 2 : 1);
                    end
                end
            end
        join
        checks++; if (bus.dropped !== 1'b0) begin errors++; $display("FAIL b2b_dropped: got %b required 0", bus.dropped); end
    endtask

    task automatic test_overflow();
        fork
            begin
                int lvl;
                bus.doOut = 1'b1; bus.dbus = 8'd10; exp_q.push_back(8'd10);
                @(negedge clk);
                bus.doOut = 1'b0;
                repeat (2) @(negedge clk);
                lvl = 0;
                for (int i = 0; i < 5; i++) begin
                    checks++; if (bus.full !== (lvl == DEPTH)) begin
                        errors++; $display("FAIL ovf_full_before[%0d]: got %b required %b", i, bus.full, lvl == DEPTH);
                    end
                    bus.doOut = 1'b1; bus.dbus = 8'(11 + i);
                    if (lvl < DEPTH) begin
                        exp_q.push_back(8'(11 + i));
                        lvl++;
                    end
                    @(negedge clk);
                end
                bus.doOut = 1'b0;
                checks++; if (bus.full !== 1'b1) begin errors++; $display("FAIL ovf_full: got %b required 1", bus.full); end
                checks++; if (bus.dropped !== 1'b1) begin errors++; $display("FAIL ovf_dropped: got %b required 1", bus.dropped); end
            end
            begin
                logic [7:0] d, e;
                logic p, s, g;
                int bc, w;
                for (int f = 0; f < 5; f++) begin
                    rx_frame(d, p, s, bc, w, g);
                    e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
                    checks++; if (d !== e) begin errors++; $display("FAIL ovf_data[%0d]: got %h required %h", f, d, e); end
                end
            end
        join
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL ovf_leftover: got %0d queued required 0", exp_q.size()); end
        checks++; if (bus.dropped !== 1'b1 || bus.full !== 1'b0) begin
            errors++; $display("FAIL ovf_sticky: dropped=%b full=%b required dropped=1 full=0", bus.dropped, bus.full);
        end
        apply_reset();
        checks++; if (bus.dropped !== 1'b0) begin errors++; $display("FAIL ovf_dropped_clear: got %b required 0", bus.dropped); end
    endtask

    task automatic test_simul_push_pop();
        fork
            begin
                bus.doOut = 1'b1; bus.dbus = 8'h21; exp_q.push_back(8'h21);
                @(negedge clk);
                bus.doOut = 1'b0;
                repeat (2) @(negedge clk);
                for (int i = 0; i < 4; i++) begin
                    bus.doOut = 1'b1; bus.dbus = 8'(8'h22 + i); exp_q.push_back(8'(8'h22 + i));
                    @(negedge clk);
                end
                bus.doOut = 1'b0;
                repeat (FRAME_CYC + 2 - 7) @(negedge clk);
                checks++; if (bus.full !== 1'b1) begin errors++; $display("FAIL spp_full_before: got %b required 1", bus.full); end
                bus.doOut = 1'b1; bus.dbus = 8'h26; exp_q.push_back(8'h26);
                @(negedge clk);
                bus.doOut = 1'b0;
                checks++; if (bus.full !== 1'b1) begin errors++; $display("FAIL spp_full_after: got %b required 1", bus.full); end
                checks++; if (bus.dropped !== 1'b0) begin errors++; $display("FAIL spp_dropped: got %b required 0", bus.dropped); end
            end
            begin
                logic [7:0] d, e;
                logic p, s, g;
                int bc, w;
                for (int f = 0; f < 6; f++) begin
                    rx_frame(d, p, s, bc, w, g);
                    e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
                    checks++; if (d !== e) begin errors++; $display("FAIL spp_data[%0d]: got %h required %h", f, d, e); end
                end
            end
        join
    endtask

    task automatic test_reset_mid_frame();
        int bad;
        apply_reset();
        bus.doOut = 1'b1; bus.dbus = 8'h37;
        @(negedge clk);
        bus.dbus = 8'h5A;
        @(negedge clk);
        bus.doOut = 1'b0;
        repeat (4 * CLKS_PER_BIT + 1) @(negedge clk);
        checks++; if (bus.txd !== 1'b0 || bus.busy !== 1'b1) begin
            errors++; $display("FAIL mid_bit3: txd=%b busy=%b required txd=0 busy=1", bus.txd, bus.busy);
        end
        resetB = 1'b0;
        #1;
        checks++; if (bus.txd !== 1'b1) begin errors++; $display("FAIL mid_reset_txd: got %b required 1", bus.txd); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL mid_reset_busy: got %b required 0", bus.busy); end
        @(negedge clk);
        resetB = 1'b1;
        bad = 0;
        for (int k = 0; k < 3 * FRAME_CYC; k++) begin
            @(negedge clk);
            if (bus.txd !== 1'b1 || bus.busy !== 1'b0) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL mid_no_frame: got %0d active cycles required 0", bad); end
        checks++; if (bus.full !== 1'b0) begin errors++; $display("FAIL mid_full: got %b required 0", bus.full); end
    endtask

`ifdef OUT_PORT_UART_PARITY_EN
    task automatic test_parity();
        apply_reset();
        fork
            begin
                bus.doOut = 1'b1; bus.dbus = 8'h07; exp_q.push_back(8'h07);
                @(negedge clk);
                bus.dbus = 8'h03; exp_q.push_back(8'h03);
                @(negedge clk);
                bus.doOut = 1'b0;
            end
            begin
                logic [7:0] d, e;
                logic p, s, g;
                int bc, w;
                for (int f = 0; f < 2; f++) begin
                    rx_frame(d, p, s, bc, w, g);
                    e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
                    checks++; if (d !== e) begin errors++; $display("FAIL par_data[%0d]: got %h required %h", f, d, e); end
                    checks++; if (p !== ^e) begin errors++; $display("FAIL par_bit[%0d]: got %b required %b", f, p, ^e); end
                    checks++; if (bc !== 11 * CLKS_PER_BIT) begin
                        errors++; $display("FAIL par_len[%0d]: got %0d required %0d", f, bc, 11 * CLKS_PER_BIT);
                    end
                end
            end
        join
    endtask
`endif

    initial begin
        test_reset();
        @(negedge clk);
        test_single_byte();
        test_back_to_back();
        test_overflow();
        test_simul_push_pop();
        test_reset_mid_frame();
`ifdef OUT_PORT_UART_PARITY_EN
        test_parity();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/out_port_uart.md
Name: out_port_uart

Overview:
- Consumer side of the CPU output port.
- Each cycle the control word asserts doOut, the block samples the data bus, exactly as the output register does.
- Sampled bytes go into a small FIFO and are then serialized on a UART-style TX line (8N1, LSB first).
- Lets the simulated machine stream its output to an external terminal model without stalling the CPU.

Parameters:
- CLKS_PER_BIT, 16, clk cycles per serial bit; legal range 2..255.
- DEPTH, 4, FIFO entries; must be a power of two, 2..16.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- resetB  input  1  asynchronous, active-low reset.
- doOut  input  1  output-strobe control bit; byte captured on a rising clk edge while high.
- dbus  input  8  data bus, sampled together with doOut.
- txd  output  1  serial line; idles high.
- busy  output  1  high while a frame is being shifted out.
- full  output  1  FIFO holds DEPTH entries.
- dropped  output  1  sticky flag; set when a write arrives while the FIFO is full.

Behaviour:
- Reset (resetB low, asynchronous, takes effect immediately):
  - txd=1, busy=0, full=0, dropped=0.
  - FIFO empty, pointers 0, bit counter 0, baud counter 0, state IDLE.
- Reset release is synchronous to the next clk edge.
- Reset asserted mid-frame aborts the frame; txd returns to 1 at once.
- Capture:
  - On a rising edge with doOut=1 and the FIFO not full, dbus is written at wr_ptr and wr_ptr increments modulo DEPTH.
  - doOut=1 with the FIFO full discards the byte and sets dropped. dropped clears only on reset.
- FIFO:
  - Occupancy count runs 0..DEPTH; full = (count==DEPTH).
  - Simultaneous write and pop on the same edge leaves count unchanged and is legal when full. The pop frees a slot, so the write is accepted and dropped is not set.
  - Pointers wrap at DEPTH.
- TX state machine (START, DATA and STOP each last exactly CLKS_PER_BIT cycles per bit):
  - IDLE: txd=1. If count>0, pop the head into the shift register, set busy=1, go to START on the next edge.
  - START: txd=0 for CLKS_PER_BIT cycles.
  - DATA: 8 bits, LSB first, each CLKS_PER_BIT cycles; shift right at each bit boundary.
  - STOP: txd=1 for CLKS_PER_BIT cycles, then return to IDLE.
  - busy falls on the IDLE entry edge. Back-to-back frames therefore carry one idle cycle between STOP and the next START.
- Latency: doOut edge into an empty FIFO makes txd fall (start bit) 2 clk edges later, one edge to write and one to pop/enter START.
- Frame length: 10*CLKS_PER_BIT cycles, or 11*CLKS_PER_BIT with parity.
- Outputs are registered; txd is glitch-free.

Optional Feature:
- Macro: OUT_PORT_UART_PARITY_EN.
- Defined: a PARITY state between DATA and STOP transmits the even-parity bit (XOR of the 8 data bits) for CLKS_PER_BIT cycles.
- Undefined: no PARITY state; plain 8N1.

Decomposition:
- Shared package nic8_uart_pkg:
  - state encoding typedef (IDLE, START, DATA, PARITY, STOP);
  - constants UART_DATA_BITS=8, UART_IDLE_LEVEL=1.
- One natural sub-module: out_fifo, parameterized DEPTH x 8.
  - Inputs: push, pop, din.
  - Outputs: dout, count, full, empty.
- Top level holds the capture logic, baud counter and TX FSM.

Test Plan:
- Reset mid-frame: drop resetB during DATA bit 3 -> txd=1, busy=0 immediately; after release, count=0 and no further frame.
- Single byte: CLKS_PER_BIT=4, doOut=1 with dbus=8'hA5 for one cycle -> start bit 2 edges later, then bits 1,0,1,0,0,1,0,1, then stop; busy high for 40 cycles.
- Back-to-back: write 8'h01, 8'h02, 8'h03 on consecutive cycles -> three frames in order, each separated by exactly one idle cycle; dropped=0.
- Overflow: DEPTH=4, while the first frame is in flight write 5 more bytes (11..15) -> full=1 after 4, 5th byte lost, dropped=1; bytes 11..14 transmitted.
- Simultaneous push/pop when full: push coincides with the IDLE pop edge -> byte accepted, count stays 4, dropped stays 0.
- Parity (macro defined): dbus=8'h07 -> parity bit 1, frame 11*CLKS_PER_BIT cycles. dbus=8'h03 -> parity bit 0.
